// File: rtl/asram_ctrl.sv
// asram_ctrl -- timed WISHBONE slave for a 16-bit asynchronous SRAM.
//
// Runs each access through setup, strobe and hold phases with parameterised
// wait states. Every SRAM control pin comes straight from a flop, so the pins
// are glitch-free. wb_ack_o is returned only once the access has met SRAM
// timing.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock; asynchronous active-high reset
//   wb_adr_i[18:0]         byte address (bit 0 ignored)
//   wb_dat_i / wb_dat_o    write data / read data (valid while wb_ack_o=1)
//   wb_we_i, wb_sel_i[1:0] write select, byte lanes ([1]=upper)
//   wb_stb_i, wb_cyc_i     request qualifiers
//   wb_ack_o               single-cycle acknowledge
//   sram_dq_i / sram_dq_o  pad data in / out; sram_dq_oe = 1 drives the pad
//   sram_addr[17:0]        word address
//   sram_ub_n, sram_lb_n   byte masks
//   sram_we_n, sram_ce_n, sram_oe_n   SRAM strobes
//
// Optional: defining ASRAM_CTRL_BUSY_CNT_EN adds busy_clr_i and
// busy_cnt_o[15:0]. busy_cnt_o is a saturating count of non-IDLE cycles.
module asram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [18:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic [17:0] sram_addr,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n
`ifdef ASRAM_CTRL_BUSY_CNT_EN
  ,
  input  logic        busy_clr_i,
  output logic [15:0] busy_cnt_o
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ACT   = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_PULSE = 3'd3;
  localparam logic [2:0] WR_HOLD  = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;   // cyc seen low during a write
  logic             ack_q, ack_d;
  logic [15:0]      dat_o_q, dat_o_d;
  logic [15:0]      dq_o_q, dq_o_d;
  logic             dq_oe_q, dq_oe_d;
  logic [17:0]      addr_q, addr_d;
  logic             ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic             we_n_q, we_n_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d;

  logic unused_adr0;
  assign unused_adr0 = wb_adr_i[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    dat_o_d = dat_o_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    addr_d  = addr_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    we_n_d  = we_n_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    case (state_q)
      IDLE: if (wb_cyc_i && wb_stb_i) begin
        addr_d  = wb_adr_i[18:1];
        ub_n_d  = ~wb_sel_i[1];
        lb_n_d  = ~wb_sel_i[0];
        dq_o_d  = wb_dat_i;
        ce_n_d  = 1'b0;
        abort_d = 1'b0;
        if (wb_we_i) begin
          // Data is driven one cycle before we_n falls.
          dq_oe_d = 1'b1;
          state_d = WR_SETUP;
        end else begin
          oe_n_d  = 1'b0;
          cnt_d   = RD_LOAD;
          state_d = RD_ACT;
        end
      end
      RD_ACT: begin
        if (!wb_cyc_i || cnt_q == '0) begin
          // A read can be abandoned at once. It leaves no state in the SRAM.
          if (wb_cyc_i) begin
            dat_o_d = sram_dq_i;
            ack_d   = 1'b1;
          end
          oe_n_d  = 1'b1;
          ce_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SETUP: begin
        abort_d = abort_q | ~wb_cyc_i;
        we_n_d  = 1'b0;
        cnt_d   = WR_LOAD;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        // A write runs to completion even if cyc drops. A truncated we_n
        // pulse could corrupt the SRAM cell.
        abort_d = abort_q | ~wb_cyc_i;
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: begin
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ack_d   = ~(abort_q | ~wb_cyc_i);
        state_d = ACK;
      end
      ACK:     state_d = IDLE;  // requests ignored: forces a turnaround cycle
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      addr_q  <= '0;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      addr_q  <= addr_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      we_n_q  <= we_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_o_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_addr  = addr_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;

`ifdef ASRAM_CTRL_BUSY_CNT_EN
  logic [15:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (busy_clr_i)
      busy_d = '0;
    else if (state_q != IDLE && busy_q != 16'hFFFF)
      busy_d = busy_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_cnt_o = busy_q;
`endif

endmodule

// File: tb/tb_asram_ctrl.sv
// Directed testbench for asram_ctrl with default timing (RD_WAIT=2, WR_WAIT=2).
// A small behavioural SRAM answers reads and applies byte-masked writes.
module tb_asram_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [18:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_we_i  = 1'b0;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

  asram_ctrl #(.RD_WAIT(2), .WR_WAIT(2), .CNT_W(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_addr(sram_addr), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural SRAM, 64 words
  logic [15:0] mem [0:63];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;
  always @(posedge wb_clk_i) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_addr[5:0]][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) mem[sram_addr[5:0]][7:0]  <= sram_dq_o[7:0];
    end
  end

  // Pin-level invariant monitor
  int both_low = 0, we_with_oe = 0;
  logic prev_dq_oe = 1'b0;
  always @(negedge wb_clk_i) begin
    if (!sram_oe_n && !sram_we_n) both_low++;
    if (sram_dq_oe && !prev_dq_oe && !sram_we_n) we_with_oe++;
    prev_dq_oe = sram_dq_oe;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          ack_at, we_lo, oe_lo, dqoe_cnt, ce_start;
  logic [15:0] rd_seen, dq_seen;
  logic [17:0] addr_seen;
  logic [1:0]  bm_seen;

  // Call right after a negedge. Cycle i is sampled at the i-th following
  // negedge, so cycle 1 follows the edge that accepts the request.
  task automatic access(input bit we, input logic [18:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input bit hold_stb);
    ack_at = 0; we_lo = 0; oe_lo = 0; dqoe_cnt = 0; ce_start = 0;
    rd_seen = '0; dq_seen = '0; addr_seen = '0; bm_seen = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int i = 1; i <= 20 && ack_at == 0; i++) begin
      @(negedge wb_clk_i);
      if (!sram_ce_n && ce_start == 0) begin
        ce_start = i; addr_seen = sram_addr; bm_seen = {sram_ub_n, sram_lb_n};
        dq_seen = sram_dq_o;
      end
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (sram_dq_oe) dqoe_cnt++;
      if (wb_ack_o) begin ack_at = i; rd_seen = wb_dat_o; end
    end
    if (!hold_stb) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
  endtask

  // One cycle after the ack: ack must be gone and the chip deselected.
  task automatic post(input string tag);
    @(negedge wb_clk_i);
    chk({tag, "_ack_drop"}, wb_ack_o, 0);
    chk({tag, "_ce_idle"}, sram_ce_n, 1);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, 6'b111110);
    chk("rst_data", {wb_dat_o, sram_dq_o}, 0);
    chk("rst_addr", sram_addr, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // 1: asynchronous reset in RD_ACT
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 19'h10; wb_sel_i = 2'b11;
    @(negedge wb_clk_i);
    chk("t1_rd_active", {sram_ce_n, sram_oe_n}, 2'b00);
    #2 wb_rst_i = 1'b1;
    #1 chk("t1_async_rst", {sram_ce_n, sram_oe_n, wb_ack_o}, 3'b110);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // 2: full write. Ack arrives in the cycle after edge N+4.
    access(1'b1, 19'h00010, 16'hA55A, 2'b11, 1'b0);
    chk("t2_ack_at", ack_at, 5);
    chk("t2_we_lo", we_lo, 2);
    chk("t2_dqoe", dqoe_cnt, 4);
    chk("t2_oe_lo", oe_lo, 0);
    chk("t2_addr", addr_seen, 18'h00008);
    chk("t2_bm", bm_seen, 2'b00);
    chk("t2_dq", dq_seen, 16'hA55A);
    post("t2");

    // 3: read back. Ack arrives in the cycle after edge N+2.
    access(1'b0, 19'h00010, 16'h0000, 2'b11, 1'b0);
    chk("t3_ack_at", ack_at, 3);
    chk("t3_oe_lo", oe_lo, 2);
    chk("t3_we_lo", we_lo, 0);
    chk("t3_data", rd_seen, 16'hA55A);
    post("t3");

    // sel=00 still runs full timing and acks, with no lane enabled.
    access(1'b1, 19'h00010, 16'h0000, 2'b00, 1'b0);
    chk("sel0_ack_at", ack_at, 5);
    chk("sel0_bm", bm_seen, 2'b11);
    post("sel0");
    access(1'b0, 19'h00010, 16'h0000, 2'b11, 1'b0);
    chk("sel0_keep", rd_seen, 16'hA55A);
    post("sel0rd");

    // 4: upper-byte write into 3456
    access(1'b1, 19'h00020, 16'h3456, 2'b11, 1'b0);
    post("t4a");
    access(1'b1, 19'h00020, 16'h12FF, 2'b10, 1'b0);
    chk("t4_bm", bm_seen, 2'b01);
    post("t4b");
    access(1'b0, 19'h00020, 16'h0000, 2'b11, 1'b0);
    chk("t4_data", rd_seen, 16'h1256);
    post("t4c");

    // 5: back-to-back read then write with stb held. ce_n stays high for the
    // ack cycle plus one turnaround cycle, so the write starts in cycle 2.
    access(1'b0, 19'h00010, 16'h0000, 2'b11, 1'b1);
    chk("t5_rd_data", rd_seen, 16'hA55A);
    access(1'b1, 19'h00020, 16'h7777, 2'b01, 1'b0);
    chk("t5_gap", ce_start, 2);
    chk("t5_wr_ack_at", ack_at, 6);
    chk("t5_bm", bm_seen, 2'b10);
    post("t5");
    access(1'b0, 19'h00020, 16'h0000, 2'b11, 1'b0);
    chk("t5_data", rd_seen, 16'h1277);
    post("t5rd");

    // 6: cyc dropped during WR_PULSE. The pulse completes, with no ack.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 19'h00030; wb_dat_i = 16'hBEEF; wb_sel_i = 2'b11;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("t6_in_pulse", sram_we_n, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    we_lo = 1; ack_at = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      if (!sram_we_n) we_lo++;
      if (wb_ack_o) ack_at++;
    end
    chk("t6_we_lo", we_lo, 2);
    chk("t6_no_ack", ack_at, 0);
    chk("t6_idle", {sram_ce_n, sram_dq_oe}, 2'b10);
    access(1'b0, 19'h00030, 16'h0000, 2'b11, 1'b0);
    chk("t6_rd_ack_at", ack_at, 3);
    chk("t6_data", rd_seen, 16'hBEEF);
    post("t6");

    // cyc dropped during a read: abort with no ack.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 19'h00010;
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rdab_ctl", {wb_ack_o, sram_ce_n, sram_oe_n}, 3'b011);
    @(negedge wb_clk_i);
    access(1'b0, 19'h00010, 16'h0000, 2'b11, 1'b0);
    chk("rdab_next", ack_at, 3);
    post("rdab");

    chk("inv_oe_we", both_low, 0);
    chk("inv_we_dqoe", we_with_oe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
